// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning the HI/LO register pair.
// A launch computes the full result at once into pending registers, then a
// countdown models the multi-cycle latency (5 for multiply, 10 for divide)
// and commits pending to HI/LO on the last busy edge.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU (op 9/10).
module e_mdu (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic [31:0] o_result,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMfhi  = 4'd5,
        OpMflo  = 4'd6,
        OpMthi  = 4'd7,
        OpMtlo  = 4'd8,
        OpMadd  = 4'd9,
        OpMaddu = 4'd10
    } op_e;

    localparam logic [3:0] MulLatency = 4'd5;
    localparam logic [3:0] DivLatency = 4'd10;

    // Architectural and in-flight state
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [3:0]  cnt_q, cnt_d;

    // Op decode
    logic op_mul;
    logic op_div;
    logic op_madd;
    logic op_signed;
    logic busy;
    logic launch;

    // Datapath results
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic [63:0] madd_sum;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign busy   = (cnt_q != 4'd0);
    assign o_busy = busy;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

    assign op_mul = (i_op == OpMult) || (i_op == OpMultu);
    assign op_div = (i_op == OpDiv) || (i_op == OpDivu);
`ifdef MDU_MADD_EN
    assign op_madd = (i_op == OpMadd) || (i_op == OpMaddu);
`else
    // Without the feature, op 9/10 decode as NONE.
    assign op_madd = 1'b0;
`endif
    assign op_signed = (i_op == OpMult) || (i_op == OpDiv) || (i_op == OpMadd);

    // Launch only from idle; requests while busy are dropped, not queued.
    assign launch = i_start && !busy && (op_mul || op_div || op_madd);

    // 64-bit product: sign- or zero-extend both operands, keep the low 64 bits.
    always_comb begin
        a_ext    = op_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
        b_ext    = op_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
        product  = a_ext * b_ext;
        madd_sum = {hi_q, lo_q} + product;
    end

    // Divide on magnitudes, then restore signs. Working unsigned keeps
    // 0x80000000 / -1 well defined: the quotient wraps back to 0x80000000.
    always_comb begin
        a_neg = op_signed && i_a[31];
        b_neg = op_signed && i_b[31];
        a_mag = a_neg ? (32'd0 - i_a) : i_a;
        b_mag = b_neg ? (32'd0 - i_b) : i_b;
        if (b_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        remainder = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Next state: countdown/commit while busy, otherwise launch or MTHI/MTLO.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        cnt_d     = cnt_q;

        if (busy) begin
            cnt_d = cnt_q - 4'd1;
            if ((cnt_q == 4'd1) && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (launch) begin
            if (op_div) begin
                cnt_d     = DivLatency;
                pend_hi_d = remainder;
                pend_lo_d = quotient;
                // Divide by zero still takes the full latency but commits nothing.
                pend_wr_d = (i_b != 32'd0);
            end else if (op_madd) begin
                cnt_d     = MulLatency;
                pend_hi_d = madd_sum[63:32];
                pend_lo_d = madd_sum[31:0];
                pend_wr_d = 1'b1;
            end else begin
                cnt_d     = MulLatency;
                pend_hi_d = product[63:32];
                pend_lo_d = product[31:0];
                pend_wr_d = 1'b1;
            end
        end else if (i_op == OpMthi) begin
            hi_d = i_a;
        end else if (i_op == OpMtlo) begin
            lo_d = i_a;
        end
    end

    // State registers; reset wipes everything including any in-flight result.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            cnt_q     <= cnt_d;
        end
    end

    // MFHI/MFLO read port; reflects committed HI/LO even while busy.
    always_comb begin
        o_result = 32'd0;
        if (i_op == OpMfhi) begin
            o_result = hi_q;
        end else if (i_op == OpMflo) begin
            o_result = lo_q;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu. Stimulus pushes expected commits;
// a negedge monitor pops one on every busy->idle transition.
module tb_e_mdu;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [3:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_busy;
    logic [31:0] o_result;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   busy_cnt = 0;
    logic busy_prev = 1'b0;

    e_mdu dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (o_busy),
        .o_result (o_result),
        .o_hi     (o_hi),
        .o_lo     (o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles and compare on every commit.
    always @(negedge i_clk) begin
        if (i_reset) begin
            exp_q.delete();
            busy_cnt  = 0;
            busy_prev = 1'b0;
        end else begin
            if (o_busy) begin
                busy_cnt++;
            end else if (busy_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got busy end, expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    check32("busy_cycles", busy_cnt, mon_e.n);
                    check32("commit_hi", o_hi, mon_e.hi);
                    check32("commit_lo", o_lo, mon_e.lo);
                end
                busy_cnt = 0;
            end
            busy_prev = o_busy;
        end
    end

    // Reference model: plain 64-bit arithmetic on the op's definition.
    task automatic model_launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int              sa_i = a;
        int              sb_i = b;
        longint          sa = sa_i;
        longint          sb = sb_i;
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint unsigned acc = {m_hi, m_lo};
        longint unsigned res = acc;
        longint          q;
        longint          r;
        exp_t            e;
        e.n = (op == 4'd3 || op == 4'd4) ? 10 : 5;
        case (op)
            4'd1: res = sa * sb;
            4'd2: res = ua * ub;
            4'd3: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            4'd4: if (b != 0) begin
                q = ua / ub;
                r = ua % ub;
                res = {r[31:0], q[31:0]};
            end
            4'd9:  res = acc + sa * sb;
            4'd10: res = acc + ua * ub;
            default: res = acc;
        endcase
        m_hi = res[63:32];
        m_lo = res[31:0];
        e.hi = m_hi;
        e.lo = m_lo;
        exp_q.push_back(e);
    endtask

    // All drive tasks start and end at 1 time unit after a rising edge.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_op    = 4'd0;
        model_launch(op, a, b);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (o_busy && k < 40) begin
            @(posedge i_clk);
            #1;
            k++;
        end
        if (o_busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy after 40 cycles, expected idle");
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        i_op = op;
        i_a  = a;
        @(posedge i_clk);
        #1;
        i_op = 4'd0;
        if (op == 4'd7) m_hi = a;
        else m_lo = a;
    endtask

    task automatic mf_check();
        i_op = 4'd5;
        #1;
        check32("mfhi", o_result, m_hi);
        i_op = 4'd6;
        #1;
        check32("mflo", o_result, m_lo);
        i_op = 4'd0;
        check32("o_hi", o_hi, m_hi);
        check32("o_lo", o_lo, m_lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        i_reset = 1'b1;
        i_start = 1'b0;
        i_op    = 4'd5;
        i_a     = 32'd0;
        i_b     = 32'd0;
        repeat (2) @(posedge i_clk);
        #1;
        check32("reset_busy", o_busy, 0);
        check32("reset_hi", o_hi, 0);
        check32("reset_lo", o_lo, 0);
        check32("reset_result", o_result, 0);
        // MTLO must not take effect while reset is held.
        i_op = 4'd8;
        i_a  = 32'hFFFF_FFFF;
        @(posedge i_clk);
        #1;
        check32("reset_mtlo_lo", o_lo, 0);
        i_op    = 4'd0;
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        // Directed multiply / divide cases
        launch(4'd1, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        mf_check();
        launch(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        mf_check();
        launch(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        mf_check();
        launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        mf_check();

        // Divide by zero leaves HI/LO as written by MTHI/MTLO
        mt(4'd7, 32'h1234_5678);
        mt(4'd8, 32'h9ABC_DEF0);
        launch(4'd4, 32'h0000_0077, 32'd0);
        wait_idle();
        mf_check();

        // Reset in busy cycle 3 of MULT 3x4
        launch(4'd1, 32'd3, 32'd4);
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        #1;
        check32("midreset_busy", o_busy, 0);
        check32("midreset_hi", o_hi, 0);
        check32("midreset_lo", o_lo, 0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        repeat (8) @(posedge i_clk);
        #1;
        check32("postreset_busy", o_busy, 0);
        check32("postreset_lo", o_lo, 0);
        check32("postreset_hi", o_hi, 0);

        // MTLO and relaunch during busy are both ignored
        launch(4'd1, 32'h1234_5678, 32'hFFFF_FFFD);
        i_op = 4'd8;
        i_a  = 32'h0000_5555;
        @(posedge i_clk);
        #1;
        i_start = 1'b1;
        i_op    = 4'd2;
        i_a     = 32'd7;
        i_b     = 32'd9;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_op    = 4'd0;
        wait_idle();
        mf_check();

        // MADDU 1x1 on HI=0, LO=0xFFFFFFFF
        mt(4'd7, 32'd0);
        mt(4'd8, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        launch(4'd10, 32'd1, 32'd1);
        wait_idle();
        mf_check();
`else
        i_start = 1'b1;
        i_op    = 4'd10;
        i_a     = 32'd1;
        i_b     = 32'd1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_op    = 4'd0;
        for (int i = 0; i < 6; i++) begin
            check32("madd_off_busy", o_busy, 0);
            @(posedge i_clk);
            #1;
        end
        mf_check();
`endif

        // Randomised ops against the model
        for (int i = 0; i < 40; i++) begin
`ifdef MDU_MADD_EN
            sel = $urandom_range(0, 7);
`else
            sel = $urandom_range(0, 5);
`endif
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 16);
                default: rb = $urandom;
            endcase
            case (sel)
                0: op = 4'd1;
                1: op = 4'd2;
                2: op = 4'd3;
                3: op = 4'd4;
                4: op = 4'd7;
                5: op = 4'd8;
                6: op = 4'd9;
                default: op = 4'd10;
            endcase
            if (op == 4'd7 || op == 4'd8) begin
                mt(op, ra);
            end else begin
                launch(op, ra, rb);
                wait_idle();
            end
            mf_check();
        end

        repeat (2) @(posedge i_clk);
        #1;
        check32("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
